// File: rtl/axi_arb_pkg.sv
// Shared types and widths for the AXI4 write-path arbiter.
// Provides burst/response enums, AW FSM states and midx_w().
package axi_arb_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic {
    AW_IDLE  = 1'b0,
    AW_GRANT = 1'b1
  } aw_state_t;

  function automatic int midx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_arb_fifo.sv
// Synchronous FIFO holding granted master indices in AW order.
// Ports: clk/rst_n, push_i/data_i, pop_i, head_o, full_o, empty_o.
module axi_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wp_d  = do_push ? inc(wp_q) : wp_q;
    rp_d  = do_pop ? inc(rp_q) : rp_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      (do_push & ~do_pop): cnt_d = cnt_q + 1'b1;
      (do_pop & ~do_push): cnt_d = cnt_q - 1'b1;
      default:             cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// N-to-1 AXI4 write arbiter: round-robin AW, W in grant order, B by ID.
// Ports: per-master s_aw*/s_w*/s_b* (packed slices), one m_aw*/m_w*/m_b*.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int NUM_MASTERS  = 4,
  parameter  int ID_WIDTH     = 4,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int DATA_WIDTH   = 32,
  parameter  int W_FIFO_DEPTH = 4,
  localparam int MIDX_W       = midx_w(NUM_MASTERS),
  localparam int N            = NUM_MASTERS,
  localparam int SW           = DATA_WIDTH / 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N*ID_WIDTH-1:0]      s_awid,
  input  logic [N*ADDR_WIDTH-1:0]    s_awaddr,
  input  logic [N*LEN_W-1:0]         s_awlen,
  input  logic [N*SIZE_W-1:0]        s_awsize,
  input  logic [N*BURST_W-1:0]       s_awburst,
  input  logic [N-1:0]               s_awvalid,
  output logic [N-1:0]               s_awready,
  input  logic [N*DATA_WIDTH-1:0]    s_wdata,
  input  logic [N*SW-1:0]            s_wstrb,
  input  logic [N-1:0]               s_wlast,
  input  logic [N-1:0]               s_wvalid,
  output logic [N-1:0]               s_wready,
  output logic [ID_WIDTH-1:0]        s_bid,
  output logic [RESP_W-1:0]          s_bresp,
  output logic [N-1:0]               s_bvalid,
  input  logic [N-1:0]               s_bready,
  output logic [ID_WIDTH+MIDX_W-1:0] m_awid,
  output logic [ADDR_WIDTH-1:0]      m_awaddr,
  output logic [LEN_W-1:0]           m_awlen,
  output logic [SIZE_W-1:0]          m_awsize,
  output logic [BURST_W-1:0]         m_awburst,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [DATA_WIDTH-1:0]      m_wdata,
  output logic [SW-1:0]              m_wstrb,
  output logic                       m_wlast,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [ID_WIDTH+MIDX_W-1:0] m_bid,
  input  logic [RESP_W-1:0]          m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready
);

  aw_state_t   state_q, state_d;
  logic [MIDX_W-1:0] gnt_q, gnt_d;
  logic [MIDX_W-1:0] rr_q, rr_d;
  logic [MIDX_W-1:0] pick;
  logic [MIDX_W-1:0] head;
  logic [MIDX_W-1:0] bidx;
  logic        fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic        b_hit;
  int          gi, hi;

  function automatic logic [MIDX_W-1:0] rr_pick(
    input logic [N-1:0]      req,
    input logic [MIDX_W-1:0] ptr
  );
    logic [MIDX_W:0]   s;
    logic [MIDX_W-1:0] k;
    logic [MIDX_W-1:0] r;
    logic              f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr} + (MIDX_W+1)'(i);
      if (s >= (MIDX_W+1)'(N)) s = s - (MIDX_W+1)'(N);
      k = s[MIDX_W-1:0];
      if (!f && req[k]) begin
        f = 1'b1;
        r = k;
      end
    end
    return r;
  endfunction

  assign pick = rr_pick(s_awvalid, rr_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    m_awvalid = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      AW_IDLE: begin
        if (|s_awvalid && !fifo_full) begin
          gnt_d   = pick;
          state_d = AW_GRANT;
        end
      end
      AW_GRANT: begin
        m_awvalid = 1'b1;
        if (m_awready) begin
          fifo_push = 1'b1;
          rr_d      = (gnt_q == MIDX_W'(N - 1))
                    ? '0 : gnt_q + 1'b1;
          state_d   = AW_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= AW_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  assign gi        = int'(gnt_q);
  assign m_awid    = {gnt_q, s_awid[gi*ID_WIDTH +: ID_WIDTH]};
  assign m_awaddr  = s_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_awlen   = s_awlen[gi*LEN_W +: LEN_W];
  assign m_awsize  = s_awsize[gi*SIZE_W +: SIZE_W];
  assign m_awburst = s_awburst[gi*BURST_W +: BURST_W];

  always_comb begin
    s_awready = '0;
    if (state_q == AW_GRANT) s_awready[gnt_q] = m_awready;
  end

  axi_arb_fifo #(
    .DEPTH (W_FIFO_DEPTH),
    .WIDTH (MIDX_W)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push_i  (fifo_push),
    .data_i  (gnt_q),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign hi       = int'(head);
  assign m_wdata  = s_wdata[hi*DATA_WIDTH +: DATA_WIDTH];
  assign m_wstrb  = s_wstrb[hi*SW +: SW];
  assign m_wlast  = s_wlast[head];
  assign m_wvalid = ~fifo_empty & s_wvalid[head];
  assign fifo_pop = m_wvalid & m_wready & m_wlast;

  always_comb begin
    s_wready = '0;
    if (!fifo_empty) s_wready[head] = m_wready;
  end

  // Out-of-range master indices are sunk so the slave never stalls.
  // Reset masks the B path so it is quiet while aresetn is low.
  assign bidx    = m_bid[ID_WIDTH +: MIDX_W];
  assign b_hit   = ({1'b0, bidx} < (MIDX_W+1)'(N));
  assign s_bid   = m_bid[ID_WIDTH-1:0];
  assign s_bresp = m_bresp;

  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b0;
    if (aresetn) begin
      if (b_hit) begin
        s_bvalid[bidx] = m_bvalid;
        m_bready       = s_bready[bidx];
      end else begin
        m_bready = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter.
// Second instance with three masters covers out-of-range B IDs.
module tb_axi_wr_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N*IW-1:0] s_awid;
  logic [N*AW-1:0] s_awaddr;
  logic [N*8-1:0]  s_awlen;
  logic [N*3-1:0]  s_awsize;
  logic [N*2-1:0]  s_awburst;
  logic [N-1:0]    s_awvalid, s_awready;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_wlast, s_wvalid, s_wready;
  logic [IW-1:0]   s_bid;
  logic [1:0]      s_bresp;
  logic [N-1:0]    s_bvalid, s_bready;
  logic [5:0]      m_awid;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wlast, m_wvalid, m_wready;
  logic [5:0]      m_bid;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;

  logic [N-1:0]  awv;
  logic [IW-1:0] awid   [N];
  logic [AW-1:0] awaddr [N];
  logic [7:0]    awlen  [N];
  logic [7:0]    wlen   [N];
  int            wpend  [N];
  int            wcnt   [N];
  logic [32:0]   wlog   [$];

  int n_chk  = 0;
  int n_pass = 0;

  assign s_awvalid = awv;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign s_awid[g*IW +: IW]   = awid[g];
    assign s_awaddr[g*AW +: AW] = awaddr[g];
    assign s_awlen[g*8 +: 8]    = awlen[g];
    assign s_awsize[g*3 +: 3]   = 3'd2;
    assign s_awburst[g*2 +: 2]  = 2'b01;
    assign s_wdata[g*DW +: DW]  =
      {8'hA0 + 8'(g), 16'h0, 8'(wcnt[g])};
    assign s_wstrb[g*SW +: SW]  = 4'hF;
    assign s_wlast[g]  = (8'(wcnt[g]) == wlen[g]);
    assign s_wvalid[g] = (wpend[g] > 0);
  end

  axi_wr_arbiter #(
    .NUM_MASTERS (N), .ID_WIDTH (IW),
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
    .W_FIFO_DEPTH (4)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .s_awid (s_awid), .s_awaddr (s_awaddr),
    .s_awlen (s_awlen), .s_awsize (s_awsize),
    .s_awburst (s_awburst), .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata (s_wdata), .s_wstrb (s_wstrb),
    .s_wlast (s_wlast), .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bid (s_bid), .s_bresp (s_bresp),
    .s_bvalid (s_bvalid), .s_bready (s_bready),
    .m_awid (m_awid), .m_awaddr (m_awaddr),
    .m_awlen (m_awlen), .m_awsize (m_awsize),
    .m_awburst (m_awburst), .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata (m_wdata), .m_wstrb (m_wstrb),
    .m_wlast (m_wlast), .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_bid (m_bid), .m_bresp (m_bresp),
    .m_bvalid (m_bvalid), .m_bready (m_bready)
  );

  logic [5:0]  b3_bid;
  logic        b3_bvalid, b3_mbready;
  logic [2:0]  b3_bready, b3_sbvalid;
  logic [3:0]  b3_sbid;
  logic [1:0]  b3_sbresp;
  logic [2:0]  x3_awready, x3_wready;
  logic [5:0]  x3_awid;
  logic [31:0] x3_awaddr, x3_wdata;
  logic [7:0]  x3_awlen;
  logic [2:0]  x3_awsize;
  logic [1:0]  x3_awburst;
  logic [3:0]  x3_wstrb;
  logic        x3_awvalid, x3_wlast, x3_wvalid;

  axi_wr_arbiter #(
    .NUM_MASTERS (3), .ID_WIDTH (4),
    .ADDR_WIDTH (32), .DATA_WIDTH (32),
    .W_FIFO_DEPTH (4)
  ) dut3 (
    .aclk (aclk), .aresetn (aresetn),
    .s_awid ('0), .s_awaddr ('0),
    .s_awlen ('0), .s_awsize ('0),
    .s_awburst ('0), .s_awvalid ('0),
    .s_awready (x3_awready),
    .s_wdata ('0), .s_wstrb ('0),
    .s_wlast ('0), .s_wvalid ('0),
    .s_wready (x3_wready),
    .s_bid (b3_sbid), .s_bresp (b3_sbresp),
    .s_bvalid (b3_sbvalid), .s_bready (b3_bready),
    .m_awid (x3_awid), .m_awaddr (x3_awaddr),
    .m_awlen (x3_awlen), .m_awsize (x3_awsize),
    .m_awburst (x3_awburst), .m_awvalid (x3_awvalid),
    .m_awready (1'b1),
    .m_wdata (x3_wdata), .m_wstrb (x3_wstrb),
    .m_wlast (x3_wlast), .m_wvalid (x3_wvalid),
    .m_wready (1'b1),
    .m_bid (b3_bid), .m_bresp (2'b00),
    .m_bvalid (b3_bvalid), .m_bready (b3_mbready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    logic [N-1:0] awhs, whs;
    #1;
    awhs = s_awvalid & s_awready;
    whs  = s_wvalid & s_wready;
    if (m_wvalid && m_wready) wlog.push_back({m_wlast, m_wdata});
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (awhs[i]) awv[i] = 1'b0;
      if (whs[i]) begin
        if (8'(wcnt[i]) == wlen[i]) begin
          wpend[i]--;
          wcnt[i] = 0;
        end else begin
          wcnt[i]++;
        end
      end
    end
  endtask

  task automatic aw_req(input int i, input logic [7:0] len);
    awv[i]   = 1'b1;
    awlen[i] = len;
    wlen[i]  = len;
    wpend[i]++;
  endtask

  function automatic logic busy();
    logic b;
    b = (awv != '0);
    for (int i = 0; i < N; i++) if (wpend[i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string tag);
    for (int c = 0; c < 60 && busy(); c++) step();
    chk(tag, busy(), 0);
  endtask

  task automatic wait_aw(input string tag);
    for (int c = 0; c < 40 && awv != '0; c++) step();
    chk(tag, awv, 0);
  endtask

  task automatic clr_model();
    awv = '0;
    for (int i = 0; i < N; i++) begin
      awid[i]   = 4'(i + 8);
      awaddr[i] = 32'((i + 1) * 32'h1000);
      awlen[i]  = 8'd0;
      wlen[i]   = 8'd0;
      wpend[i]  = 0;
      wcnt[i]   = 0;
    end
  endtask

  initial begin
    clr_model();
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bid     = 6'h00;
    m_bresp   = 2'b00;
    m_bvalid  = 1'b1;
    s_bready  = '1;
    b3_bid    = 6'h00;
    b3_bvalid = 1'b0;
    b3_bready = 3'b000;

    #2;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid",  m_wvalid,  0);
    chk("rst_bready",  m_bready,  0);
    chk("rst_awready", s_awready, 0);
    chk("rst_wready",  s_wready,  0);
    chk("rst_bvalid",  s_bvalid,  0);
    m_bvalid = 1'b0;
    #10 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    aw_req(0, 8'd0);
    aw_req(2, 8'd0);
    #1 chk("t1_lat0", m_awvalid, 0);
    step();
    chk("t1_g0_vld",  m_awvalid, 1);
    chk("t1_g0_id",   m_awid,    6'h08);
    chk("t1_g0_addr", m_awaddr,  32'h1000);
    chk("t1_g0_rdy",  s_awready, 4'b0001);
    step();
    chk("t1_gap", m_awvalid, 0);
    step();
    chk("t1_g2_vld",  m_awvalid, 1);
    chk("t1_g2_id",   m_awid,    6'h2A);
    chk("t1_g2_addr", m_awaddr,  32'h3000);
    chk("t1_g2_rdy",  s_awready, 4'b0100);
    step();
    aw_req(0, 8'd0);
    aw_req(3, 8'd0);
    step();
    chk("t1_rr3_id", m_awid, 6'h3B);
    step();
    step();
    chk("t1_wrap_id", m_awid, 6'h08);
    step();
    drain("t1_drain");

    wlog.delete();
    aw_req(1, 8'd3);
    aw_req(3, 8'd0);
    drain("t2_drain");
    chk("t2_nbeats", wlog.size(), 5);
    for (int b = 0; b < 4; b++) begin
      if (wlog.size() > b)
        chk("t2_m1_beat", wlog[b],
            {b == 3, 8'hA1, 16'h0, 8'(b)});
    end
    if (wlog.size() > 4)
      chk("t2_m3_beat", wlog[4], {1'b1, 32'hA300_0000});

    m_wready = 1'b0;
    for (int i = 0; i < N; i++) aw_req(i, 8'd0);
    wait_aw("t3_aw4");
    aw_req(0, 8'd0);
    step();
    step();
    step();
    chk("t3_full_vld", m_awvalid, 0);
    chk("t3_full_rdy", s_awready, 0);
    chk("t3_w_vld",    m_wvalid,  1);
    chk("t3_w_rdy0",   s_wready,  0);
    m_wready = 1'b1;
    #1 chk("t3_w_rdy1", s_wready, 4'b0001);
    step();
    m_wready = 1'b0;
    chk("t3_pop_vld", m_awvalid, 0);
    step();
    chk("t3_g5_vld", m_awvalid, 1);
    chk("t3_g5_rdy", s_awready, 4'b0001);
    chk("t3_g5_id",  m_awid,    6'h08);
    m_wready = 1'b1;
    drain("t3_drain");

    m_bid    = 6'h25;
    m_bresp  = 2'b10;
    m_bvalid = 1'b1;
    s_bready = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_bvalid", s_bvalid, 4'b0100);
      chk("t4_bid",    s_bid,    4'h5);
      chk("t4_bready", m_bready, 0);
      step();
    end
    chk("t4_bresp", s_bresp, 2'b10);
    s_bready = 4'hF;
    #1 chk("t4_bready1", m_bready, 1);
    m_bid    = 6'h13;
    s_bready = 4'b0010;
    #1;
    chk("t4_b1_vld", s_bvalid, 4'b0010);
    chk("t4_b1_rdy", m_bready, 1);
    m_bvalid = 1'b0;
    s_bready = '1;
    step();

    m_wready = 1'b0;
    aw_req(1, 8'd0);
    aw_req(2, 8'd0);
    wait_aw("t5_aw2");
    m_awready = 1'b0;
    aw_req(3, 8'd0);
    step();
    chk("t5_pre_aw", m_awvalid, 1);
    chk("t5_pre_w",  m_wvalid,  1);
    m_bid    = 6'h00;
    m_bvalid = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    chk("t5_awvalid", m_awvalid, 0);
    chk("t5_wvalid",  m_wvalid,  0);
    chk("t5_bready",  m_bready,  0);
    chk("t5_awready", s_awready, 0);
    chk("t5_wready",  s_wready,  0);
    chk("t5_bvalid",  s_bvalid,  0);
    clr_model();
    m_bvalid  = 1'b0;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    aw_req(3, 8'd0);
    aw_req(0, 8'd0);
    #1 chk("t5_post_lat", m_awvalid, 0);
    step();
    chk("t5_post_vld", m_awvalid, 1);
    chk("t5_post_id",  m_awid,    6'h08);
    drain("t5_drain");

    b3_bid    = 6'h37;
    b3_bvalid = 1'b1;
    b3_bready = 3'b000;
    #1;
    chk("t6_oor_rdy", b3_mbready, 1);
    chk("t6_oor_vld", b3_sbvalid, 0);
    b3_bid = 6'h17;
    #1;
    chk("t6_m1_vld", b3_sbvalid, 3'b010);
    chk("t6_m1_rdy", b3_mbready, 0);
    chk("t6_m1_id",  b3_sbid,    4'h7);
    chk("t6_awidle", x3_awvalid, 0);
    b3_bvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
